// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: oversampling ratio and FSM state encoding used by
// both the transmit and receive paths.
package uart_tx_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side transmit interface: start strobe, data word, baud tick and the
// serial line plus status flags returned by the transmitter.
interface uart_tx_if
  import uart_tx_pkg::*;
#(
  parameter int D_BIT = 8
);

  logic             s_tick;
  logic             tx_start;
  logic [D_BIT-1:0] din;
  logic             tx;
  logic             tx_busy;
  logic             tx_done_tick;

  modport master (
    output s_tick, tx_start, din,
    input  tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  s_tick, tx_start, din,
    output tx, tx_busy, tx_done_tick
  );

endinterface

// File: rtl/uart_tx_piso.sv
// Parallel-load, right-shift register feeding the serial line LSB-first.
// Exposes the current LSB and the bit that becomes the LSB after a shift.
module uart_tx_piso
  import uart_tx_pkg::*;
#(
  parameter int D_BIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [D_BIT-1:0] din,
  output logic             lsb,
  output logic             lsb_next
);

  logic [D_BIT-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {1'b0, shreg[D_BIT-1:1]};
    end
  end

  assign lsb      = shreg[0];
  assign lsb_next = shreg[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames a captured word as start, LSB-first data, optional
// parity and stop bits, timed by an external 16x oversampling tick.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int D_BIT      = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);

  localparam int TW = $clog2(SB_TICK);
  localparam int BW = $clog2(D_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(D_BIT - 1);

  tx_state_t       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            par_q, par_d;
  logic            load, shift;
  logic            lsb, lsb_next;

  uart_tx_piso #(.D_BIT(D_BIT)) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .din      (bus.din),
    .lsb      (lsb),
    .lsb_next (lsb_next)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    par_d   = par_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          load    = 1'b1;
          tick_d  = '0;
          par_d   = (^bus.din) ^ (PARITY_ODD != 0);
          state_d = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            shift  = 1'b1;
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so the pin register always
    // shows the bit belonging to the state being entered.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift ? lsb_next : lsb;
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (plain, even parity, 2 stop bits)
// share one clock and a 1-in-4 baud tick; each scenario task checks inline.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic [1:0] tick_div = 2'd0;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx_if #(.D_BIT(8)) b0 ();
  uart_tx_if #(.D_BIT(8)) b1 ();
  uart_tx_if #(.D_BIT(8)) b2 ();

  assign b0.s_tick = s_tick;
  assign b1.s_tick = s_tick;
  assign b2.s_tick = s_tick;

  uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  uart_tx #(.D_BIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_en) begin
      tick_div = tick_div + 2'd1;
      s_tick   = (tick_div == 2'd0);
    end else begin
      s_tick = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive(input int w, input logic st, input logic [7:0] d);
    case (w)
      0: begin b0.tx_start = st; b0.din = d; end
      1: begin b1.tx_start = st; b1.din = d; end
      default: begin b2.tx_start = st; b2.din = d; end
    endcase
  endtask

  // {tx, tx_busy, tx_done_tick} of the selected instance
  function automatic logic [2:0] obs(input int w);
    case (w)
      0:       return {b0.tx, b0.tx_busy, b0.tx_done_tick};
      1:       return {b1.tx, b1.tx_busy, b1.tx_done_tick};
      default: return {b2.tx, b2.tx_busy, b2.tx_done_tick};
    endcase
  endfunction

  task automatic pulse_start(input int w, input logic [7:0] d);
    @(negedge clk);
    drive(w, 1'b1, d);
    fork
      begin
        @(negedge clk);
        drive(w, 1'b0, d);
      end
    join_none
  endtask

  // Follows one frame until tx_done_tick. Ticks are counted only while busy;
  // tx is sampled at the 8th tick of each 16-tick bit slot.
  task automatic monitor(input int w, input int max_cycles, input int pause_at,
                         input int pause_len, output logic [11:0] bits,
                         output int ticks, output int dones, output int first_busy,
                         output logic first_tx, output int hold_bad,
                         output bit timed_out);
    logic [2:0] o;
    int pausing;
    bit paused;
    bits = '1; ticks = 0; dones = 0; first_busy = -1; first_tx = 1'bx;
    hold_bad = 0; timed_out = 1'b1; pausing = 0; paused = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      #1;
      o = obs(w);
      if (o[0]) dones++;
      if (o[1] && first_busy < 0) begin
        first_busy = c;
        first_tx   = o[2];
      end
      if (pausing > 0) begin
        if (o !== 3'b110) hold_bad++;
        pausing--;
        if (pausing == 0) tick_en = 1'b1;
      end
      if (o[1] && s_tick) begin
        if ((ticks % 16) == 8 && (ticks / 16) < 12) bits[ticks / 16] = o[2];
        ticks++;
        if (pause_len > 0 && !paused && ticks == pause_at) begin
          paused  = 1'b1;
          pausing = pause_len;
          tick_en = 1'b0;
        end
      end
      if (o[0]) begin
        timed_out = 1'b0;
        break;
      end
    end
    tick_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      tests_run++;
      if (obs(w) !== 3'b100) begin
        tests_failed++;
        $display("[TB] FAIL reset_state inst%0d: got %b expected 100", w, obs(w));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [11:0] bits; int ticks, dones, fb, hb; logic ftx; bit to;
    pulse_start(0, 8'hA5);
    monitor(0, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
    tests_run++;
    if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_timeout: no tx_done_tick"); end
    tests_run++;
    if (fb != 0 || ftx !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL frame_latency: busy after %0d cycles tx=%b expected 0 cycles tx=0", fb, ftx);
    end
    tests_run++;
    if (bits[9:0] !== 10'b1_1010_0101_0) begin
      tests_failed++;
      $display("[TB] FAIL frame_bits: got %b expected 1101001010", bits[9:0]);
    end
    tests_run++;
    if (ticks != 160) begin tests_failed++; $display("[TB] FAIL frame_ticks: got %0d expected 160", ticks); end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("[TB] FAIL frame_done: got %0d expected 1", dones); end
    @(negedge clk);
    #1;
    tests_run++;
    if (obs(0) !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL frame_after: got %b expected 100", obs(0));
    end
  endtask

  task automatic test_parity();
    logic [11:0] bits; int ticks, dones, fb, hb; logic ftx; bit to;
    pulse_start(1, 8'h07);
    monitor(1, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
    tests_run++;
    if (to !== 1'b0 || dones != 1) begin
      tests_failed++;
      $display("[TB] FAIL parity_done: got %0d pulses timeout=%b expected 1 pulse", dones, to);
    end
    tests_run++;
    if (bits[10:0] !== 11'b1_1_0000_0111_0) begin
      tests_failed++;
      $display("[TB] FAIL parity_bits: got %b expected 11000001110", bits[10:0]);
    end
    tests_run++;
    if (ticks != 176) begin tests_failed++; $display("[TB] FAIL parity_ticks: got %0d expected 176", ticks); end
  endtask

  task automatic test_ignore_busy();
    logic [11:0] bits; int ticks, dones, fb, hb, busy_cnt; logic ftx; bit to;
    pulse_start(0, 8'h81);
    fork
      monitor(0, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
      begin
        repeat (150) @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
      end
    join
    tests_run++;
    if (bits[9:0] !== 10'b1_1000_0001_0) begin
      tests_failed++;
      $display("[TB] FAIL busy_ignore_bits: got %b expected 1100000010", bits[9:0]);
    end
    tests_run++;
    if (to !== 1'b0 || dones != 1) begin
      tests_failed++;
      $display("[TB] FAIL busy_ignore_done: got %0d pulses expected 1", dones);
    end
    busy_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      #1;
      if (obs(0) !== 3'b100) busy_cnt++;
    end
    tests_run++;
    if (busy_cnt != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_no_queue: got %0d non-idle cycles expected 0", busy_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] bits; int ticks, dones, fb, hb; logic ftx; bit to;
    pulse_start(0, 8'h00);
    repeat (300) @(negedge clk);
    #1;
    tests_run++;
    if (obs(0) !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL midframe_pre: got %b expected 010", obs(0));
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs(0) !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL midframe_async_reset: got %b expected 100", obs(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0, 8'h3C);
    monitor(0, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
    tests_run++;
    if (to !== 1'b0 || bits[9:0] !== 10'b1_0011_1100_0 || ticks != 160) begin
      tests_failed++;
      $display("[TB] FAIL midframe_clean_frame: got bits %b ticks %0d expected 1001111000 ticks 160",
               bits[9:0], ticks);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits; int ticks, dones, fb, hb; logic ftx; bit to;
    @(negedge clk);
    drive(0, 1'b1, 8'h55);
    monitor(0, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
    tests_run++;
    if (to !== 1'b0 || bits[9:0] !== 10'b1_0101_0101_0 || ticks != 160) begin
      tests_failed++;
      $display("[TB] FAIL b2b_frame1: got bits %b ticks %0d expected 1010101010 ticks 160",
               bits[9:0], ticks);
    end
    fork
      monitor(0, 2000, 0, 0, bits, ticks, dones, fb, ftx, hb, to);
      begin
        repeat (100) @(negedge clk);
        drive(0, 1'b0, 8'h55);
      end
    join
    tests_run++;
    if (fb != 0 || ftx !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_gap: start after %0d cycles tx=%b expected 0 cycles tx=0", fb, ftx);
    end
    tests_run++;
    if (to !== 1'b0 || bits[9:0] !== 10'b1_0101_0101_0 || ticks != 160) begin
      tests_failed++;
      $display("[TB] FAIL b2b_frame2: got bits %b ticks %0d expected 1010101010 ticks 160",
               bits[9:0], ticks);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (obs(0) !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL b2b_end_idle: got %b expected 100", obs(0));
    end
  endtask

  task automatic test_stop_hold();
    logic [11:0] bits; int ticks, dones, fb, hb; logic ftx; bit to;
    pulse_start(2, 8'hA5);
    monitor(2, 3000, 16 * 9 + 4, 100, bits, ticks, dones, fb, ftx, hb, to);
    tests_run++;
    if (hb != 0) begin
      tests_failed++;
      $display("[TB] FAIL stop_hold: got %0d bad cycles expected 0", hb);
    end
    tests_run++;
    if (to !== 1'b0 || dones != 1 || ticks != 176) begin
      tests_failed++;
      $display("[TB] FAIL stop_ticks: got %0d ticks %0d pulses expected 176 ticks 1 pulse",
               ticks, dones);
    end
    tests_run++;
    if (bits[10:0] !== 11'b1_1_1010_0101_0) begin
      tests_failed++;
      $display("[TB] FAIL stop_bits: got %b expected 11101001010", bits[10:0]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_parity();
    test_ignore_busy();
    test_reset_midframe();
    test_back_to_back();
    test_stop_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
